rf_wport_arbiter: RTL and testbench

- Shares the register file's single synchronous write port between two requesters:
  - the pipeline writeback stage (WB);
  - a multi-cycle execution unit (MC), e.g. a load/mul/div unit.
- Keeps a per-register scoreboard of MC results still pending, so the decode-stage hazard logic can stall on them.
- Guarantees MC forward progress by stalling the pipeline when MC has waited too long.
- Sits between the WB/MC result buses and the regfile write inputs (wr_en, rd_addr, rd_data).

---
 rtl/rf_wport_arbiter.sv | 117 +++++++++++
 tb/tb_rf_wport_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback stage (WB) and a multi-cycle execution unit (MC). It keeps a
//   per-register scoreboard of outstanding MC results for decode hazard
//   checks. It also forces MC through, stalling the pipeline, once MC has
//   been refused STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data        writeback write request
//   mc_valid/mc_rd/mc_data        MC result; mc_ready accepts it
//   iss_valid/iss_rd              MC issue, sets the scoreboard bit
//   rs1_q/rs2_q -> rs1/rs2_busy   decode source register busy lookups
//   sb_any_busy                   any scoreboard bit set
//   pipe_stall                    pipeline freeze; WB replays its write
//   rf_wr_en/rf_rd_addr/rf_rd_data regfile write port
module rf_wport_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_rd,
  input  logic [WIDTH-1:0]  mc_data,
  output logic              mc_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] rs1_q,
  input  logic [ADDR_W-1:0] rs2_q,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              sb_any_busy,
  output logic              pipe_stall,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [WIDTH-1:0]  rf_rd_data
);

  localparam int          NREG  = 2 ** ADDR_W;
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [3:0]      starve_cnt;

  logic wb_need;
  logic mc_zero;
  logic starved;
  logic force_mc;
  logic grant_mc;
  logic mc_xfer;

  always_comb begin
    wb_need  = wb_valid && (wb_rd != '0);
    mc_zero  = mc_valid && (mc_rd == '0);
    starved  = (starve_cnt >= LIMIT);
    // MC only beats a live WB write once it has starved long enough.
    force_mc = mc_valid && !mc_zero && wb_need && starved;
    grant_mc = mc_valid && !mc_zero && (!wb_need || force_mc);

    mc_ready    = 1'b0;
    pipe_stall  = 1'b0;
    rf_wr_en    = 1'b0;
    rf_rd_addr  = '0;
    rf_rd_data  = '0;
    rs1_busy    = 1'b0;
    rs2_busy    = 1'b0;
    sb_any_busy = 1'b0;

    if (!rst) begin
      // An rd=0 result needs no port, so it is absorbed regardless of WB.
      mc_ready    = mc_zero || grant_mc;
      pipe_stall  = force_mc;
      rs1_busy    = sb[rs1_q];
      rs2_busy    = sb[rs2_q];
      sb_any_busy = |sb;
      if (grant_mc) begin
        rf_wr_en   = 1'b1;
        rf_rd_addr = mc_rd;
        rf_rd_data = mc_data;
      end else if (wb_need) begin
        rf_wr_en   = 1'b1;
        rf_rd_addr = wb_rd;
        rf_rd_data = wb_data;
      end
    end

    mc_xfer  = mc_valid && mc_ready;
    set_mask = iss_valid ? (NREG'(1) << iss_rd) : '0;
    clr_mask = mc_xfer   ? (NREG'(1) << mc_rd)  : '0;
    // Set is applied after clear so a same-cycle issue to the same
    // register keeps it busy; register 0 never tracks anything.
    sb_next  = ((sb & ~clr_mask) | set_mask) & ~NREG'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb         <= '0;
      starve_cnt <= '0;
    end else begin
      sb <= sb_next;
      if (mc_valid && !mc_ready) begin
        if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]  wb_data;
  logic              mc_valid;
  logic [ADDR_W-1:0] mc_rd;
  logic [WIDTH-1:0]  mc_data;
  logic              mc_ready;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              sb_any_busy;
  logic              pipe_stall;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [WIDTH-1:0]  rf_rd_data;

  int pass_cnt  = 0;
  int check_cnt = 0;

  rf_wport_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .sb_any_busy(sb_any_busy), .pipe_stall(pipe_stall),
    .rf_wr_en(rf_wr_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, then settle inputs and sample mid-cycle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    iss_valid = 0; iss_rd = 0; rs1_q = 0; rs2_q = 0;
  endtask

  task automatic check_port(input string tag, input logic en, input logic [ADDR_W-1:0] a,
                            input logic [WIDTH-1:0] d, input logic rdy, input logic stl);
    check({tag, ".wr_en"}, 32'(rf_wr_en), 32'(en));
    check({tag, ".addr"},  32'(rf_rd_addr), 32'(a));
    check({tag, ".data"},  rf_rd_data, d);
    check({tag, ".mc_ready"}, 32'(mc_ready), 32'(rdy));
    check({tag, ".stall"}, 32'(pipe_stall), 32'(stl));
  endtask

  initial begin
    idle_inputs();
    rst = 1;

    // Reset with both requesters active and an issue pending.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      wb_valid = 1; wb_rd = 5; wb_data = 32'h1111_2222;
      mc_valid = 1; mc_rd = 7; mc_data = 32'h3333_4444;
      iss_valid = 1; iss_rd = 9; rs1_q = 9; rs2_q = 9;
      settle();
      check_port("rst", 0, 0, 0, 0, 0);
      check("rst.rs1_busy", 32'(rs1_busy), 0);
      check("rst.rs2_busy", 32'(rs2_busy), 0);
      check("rst.any_busy", 32'(sb_any_busy), 0);
    end

    next_cycle();
    rst = 0; idle_inputs(); rs1_q = 9;
    settle();
    check("post_rst.any_busy", 32'(sb_any_busy), 0);
    check("post_rst.rs1_busy", 32'(rs1_busy), 0);
    check_port("post_rst", 0, 0, 0, 0, 0);

    // WB-only writes.
    next_cycle();
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF;
    settle();
    check_port("wb5", 1, 5, 32'hDEAD_BEEF, 0, 0);
    next_cycle();
    wb_rd = 0; wb_data = 32'h1234_5678;
    settle();
    check_port("wb0", 0, 0, 0, 0, 0);

    // Contention: four refusals, forced grant on the fifth cycle.
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      wb_valid = 1; wb_rd = 3; wb_data = 32'h0000_0033;
      mc_valid = 1; mc_rd = 7; mc_data = 32'h0000_0077;
      settle();
      if (i < 5) check_port($sformatf("starve%0d", i), 1, 3, 32'h33, 0, 0);
      else       check_port("forced", 1, 7, 32'h77, 1, 1);
    end
    next_cycle();
    mc_valid = 0;
    settle();
    check_port("wb_replay", 1, 3, 32'h33, 0, 0);

    // Scoreboard lifecycle for r10.
    next_cycle();
    idle_inputs();
    iss_valid = 1; iss_rd = 10; rs1_q = 10;
    settle();
    check("iss10.same_cycle", 32'(rs1_busy), 0);
    check("iss10.any_same", 32'(sb_any_busy), 0);
    next_cycle();
    iss_valid = 0; rs2_q = 10;
    settle();
    check("iss10.rs1_busy", 32'(rs1_busy), 1);
    check("iss10.rs2_busy", 32'(rs2_busy), 1);
    check("iss10.any", 32'(sb_any_busy), 1);
    next_cycle();
    mc_valid = 1; mc_rd = 10; mc_data = 32'hA5A5_0010;
    settle();
    check_port("mc10", 1, 10, 32'hA5A5_0010, 1, 0);
    check("mc10.no_bypass", 32'(rs1_busy), 1);
    next_cycle();
    mc_valid = 0;
    settle();
    check("mc10.cleared", 32'(rs1_busy), 0);
    check("mc10.any", 32'(sb_any_busy), 0);

    // Same-cycle set and clear of r12; issue to r0 sets nothing.
    next_cycle();
    iss_valid = 1; iss_rd = 12; rs1_q = 12;
    next_cycle();
    iss_valid = 1; iss_rd = 12;
    mc_valid = 1; mc_rd = 12; mc_data = 32'h0000_00CC;
    settle();
    check("r12.busy_before", 32'(rs1_busy), 1);
    check("r12.mc_ready", 32'(mc_ready), 1);
    next_cycle();
    iss_valid = 1; iss_rd = 0; mc_valid = 0; rs2_q = 0;
    settle();
    check("r12.set_wins", 32'(rs1_busy), 1);
    next_cycle();
    iss_valid = 0;
    mc_valid = 1; mc_rd = 12; mc_data = 32'h0000_00CD;
    settle();
    check("r0.not_set", 32'(rs2_busy), 0);
    next_cycle();
    mc_valid = 0;
    settle();
    check("r12.cleared_any", 32'(sb_any_busy), 0);

    // MC result to r0 while WB writes r4.
    next_cycle();
    wb_valid = 1; wb_rd = 4; wb_data = 32'h0000_0044;
    mc_valid = 1; mc_rd = 0; mc_data = 32'hFFFF_FFFF;
    settle();
    check_port("mc_r0", 1, 4, 32'h44, 1, 0);

    // Reset mid-operation clears the starve count and scoreboard.
    next_cycle();
    idle_inputs();
    iss_valid = 1; iss_rd = 15; rs1_q = 15;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      iss_valid = 0;
      wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
      mc_valid = 1; mc_rd = 7; mc_data = 32'h77;
      settle();
      check($sformatf("pre_rst_refuse%0d", i), 32'(mc_ready), 0);
    end
    check("pre_rst.r15_busy", 32'(rs1_busy), 1);
    next_cycle();
    rst = 1;
    settle();
    check_port("mid_rst", 0, 0, 0, 0, 0);
    check("mid_rst.rs1", 32'(rs1_busy), 0);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      rst = 0;
      settle();
      if (i < 5) check_port($sformatf("post_rst_refuse%0d", i), 1, 3, 32'h33, 0, 0);
      else       check_port("post_rst_forced", 1, 7, 32'h77, 1, 1);
      if (i == 1) check("post_rst.r15", 32'(rs1_busy), 0);
    end

    next_cycle();
    idle_inputs();
    settle();
    check_port("final_idle", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
